// File: rtl/arb_pkg.sv
// Shared types for the two-master serial bus arbiter.
package arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT1  = 2'd1,
        GRANT2  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Master identifiers (encoding matches timeout_id)
    typedef enum logic {
        M1 = 1'b0,
        M2 = 1'b1
    } mid_t;

endpackage

// File: rtl/master_arbiter.sv
// Two-master round-robin arbiter for the serial bus in front of the address
// decoder. Grants are registered (decoded from the state register). A master
// that holds the bus for HOLD_LIMIT cycles is forced off and stays ineligible
// until it drops its request.
module master_arbiter
    import arb_pkg::*;
#(
    parameter int HOLD_LIMIT = 64
) (
    input  logic clk,
    input  logic rstn,
    input  logic m1_req,
    input  logic m2_req,
    output logic m1_grant,
    output logic m2_grant,
    input  logic m1_mode,
    input  logic m1_wr_bus,
    input  logic m1_master_valid,
    input  logic m1_master_ready,
    input  logic m2_mode,
    input  logic m2_wr_bus,
    input  logic m2_master_valid,
    input  logic m2_master_ready,
    output logic m1_rd_bus,
    output logic m1_ack,
    output logic m1_slave_ready,
    output logic m1_slave_valid,
    output logic m2_rd_bus,
    output logic m2_ack,
    output logic m2_slave_ready,
    output logic m2_slave_valid,
    output logic d_mode,
    output logic d_wr_bus,
    output logic d_master_valid,
    output logic d_master_ready,
    input  logic d_rd_bus,
    input  logic d_ack,
    input  logic d_slave_ready,
    input  logic d_slave_valid,
    output logic timeout,
    output logic timeout_id
);

    localparam int CW = $clog2(HOLD_LIMIT + 1);

    state_t        state, state_nxt;
    mid_t          last_id;
    logic [CW-1:0] hold_cnt;
    logic          block_1, block_2;
    logic          elig_1, elig_2;
    logic          expire;
    logic          force_1, force_2;

    // A master just forced off may not re-enter until it drops its request
    assign elig_1  = m1_req & ~block_1;
    assign elig_2  = m2_req & ~block_2;
    // Last allowed cycle of a grant; request dropping here is a normal release
    assign expire  = (hold_cnt == CW'(HOLD_LIMIT - 1));
    assign force_1 = (state == GRANT1) & m1_req & expire;
    assign force_2 = (state == GRANT2) & m2_req & expire;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: round-robin on ties, release on drop or hold expiry
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (elig_1 && elig_2) state_nxt = (last_id == M1) ? GRANT2 : GRANT1;
                else if (elig_1)      state_nxt = GRANT1;
                else if (elig_2)      state_nxt = GRANT2;
            end
            GRANT1:  if (!m1_req || expire) state_nxt = RELEASE;
            GRANT2:  if (!m2_req || expire) state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bookkeeping: last owner, hold counter, lockout flags, timeout pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_id    <= M2;
            hold_cnt   <= '0;
            block_1    <= 1'b0;
            block_2    <= 1'b0;
            timeout    <= 1'b0;
            timeout_id <= 1'b0;
        end else begin
            if (state == GRANT1 && state_nxt == RELEASE) last_id <= M1;
            if (state == GRANT2 && state_nxt == RELEASE) last_id <= M2;

            // Zero outside a grant so every grant starts from 0
            if (state == GRANT1 || state == GRANT2) begin
                if (hold_cnt != CW'(HOLD_LIMIT)) hold_cnt <= hold_cnt + CW'(1);
            end else begin
                hold_cnt <= '0;
            end

            if (force_1)     block_1 <= 1'b1;
            else if (!m1_req) block_1 <= 1'b0;
            if (force_2)     block_2 <= 1'b1;
            else if (!m2_req) block_2 <= 1'b0;

            timeout <= force_1 | force_2;
            if (force_1 | force_2) timeout_id <= force_2;
        end
    end

    // Output decode: grants and bus mux, everything quiet outside a grant
    always_comb begin
        m1_grant       = 1'b0;
        m2_grant       = 1'b0;
        d_mode         = 1'b0;
        d_wr_bus       = 1'b0;
        d_master_valid = 1'b0;
        d_master_ready = 1'b0;
        m1_rd_bus      = 1'b0;
        m1_ack         = 1'b0;
        m1_slave_ready = 1'b0;
        m1_slave_valid = 1'b0;
        m2_rd_bus      = 1'b0;
        m2_ack         = 1'b0;
        m2_slave_ready = 1'b0;
        m2_slave_valid = 1'b0;
        case (state)
            GRANT1: begin
                m1_grant       = 1'b1;
                d_mode         = m1_mode;
                d_wr_bus       = m1_wr_bus;
                d_master_valid = m1_master_valid;
                d_master_ready = m1_master_ready;
                m1_rd_bus      = d_rd_bus;
                m1_ack         = d_ack;
                m1_slave_ready = d_slave_ready;
                m1_slave_valid = d_slave_valid;
            end
            GRANT2: begin
                m2_grant       = 1'b1;
                d_mode         = m2_mode;
                d_wr_bus       = m2_wr_bus;
                d_master_valid = m2_master_valid;
                d_master_ready = m2_master_ready;
                m2_rd_bus      = d_rd_bus;
                m2_ack         = d_ack;
                m2_slave_ready = d_slave_ready;
                m2_slave_valid = d_slave_valid;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_master_arbiter.sv
// Directed bench for master_arbiter with HOLD_LIMIT = 8.
module tb_master_arbiter;

    logic clk = 1'b0;
    logic rstn;
    logic m1_req, m2_req, m1_grant, m2_grant;
    logic m1_mode, m1_wr_bus, m1_master_valid, m1_master_ready;
    logic m2_mode, m2_wr_bus, m2_master_valid, m2_master_ready;
    logic m1_rd_bus, m1_ack, m1_slave_ready, m1_slave_valid;
    logic m2_rd_bus, m2_ack, m2_slave_ready, m2_slave_valid;
    logic d_mode, d_wr_bus, d_master_valid, d_master_ready;
    logic d_rd_bus, d_ack, d_slave_ready, d_slave_valid;
    logic timeout, timeout_id;

    int total = 0;
    int bad   = 0;

    master_arbiter #(.HOLD_LIMIT(8)) dut (
        .clk(clk), .rstn(rstn),
        .m1_req(m1_req), .m2_req(m2_req),
        .m1_grant(m1_grant), .m2_grant(m2_grant),
        .m1_mode(m1_mode), .m1_wr_bus(m1_wr_bus),
        .m1_master_valid(m1_master_valid), .m1_master_ready(m1_master_ready),
        .m2_mode(m2_mode), .m2_wr_bus(m2_wr_bus),
        .m2_master_valid(m2_master_valid), .m2_master_ready(m2_master_ready),
        .m1_rd_bus(m1_rd_bus), .m1_ack(m1_ack),
        .m1_slave_ready(m1_slave_ready), .m1_slave_valid(m1_slave_valid),
        .m2_rd_bus(m2_rd_bus), .m2_ack(m2_ack),
        .m2_slave_ready(m2_slave_ready), .m2_slave_valid(m2_slave_valid),
        .d_mode(d_mode), .d_wr_bus(d_wr_bus),
        .d_master_valid(d_master_valid), .d_master_ready(d_master_ready),
        .d_rd_bus(d_rd_bus), .d_ack(d_ack),
        .d_slave_ready(d_slave_ready), .d_slave_valid(d_slave_valid),
        .timeout(timeout), .timeout_id(timeout_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; land 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        m1_req = 0; m2_req = 0;
        m1_mode = 1; m1_wr_bus = 1; m1_master_valid = 1; m1_master_ready = 1;
        m2_mode = 1; m2_wr_bus = 0; m2_master_valid = 0; m2_master_ready = 1;
        d_rd_bus = 0; d_ack = 0; d_slave_ready = 0; d_slave_valid = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_g1", m1_grant, 0);
        chk("rst_g2", m2_grant, 0);
        chk("rst_dmode", d_mode, 0);
        chk("rst_to", timeout, 0);
        chk("rst_toid", timeout_id, 0);

        rstn = 1'b1;
        tick();

        // Tie from reset: m1 first, m2 changes ignored, then m2 after 2 idle cycles
        m1_req = 1; m2_req = 1;
        #1;
        chk("tie_lat", m1_grant, 0);
        tick();
        chk("tie_g1", m1_grant, 1);
        chk("tie_g2", m2_grant, 0);
        chk("tie_dwr", d_wr_bus, 1);
        for (int i = 0; i < 4; i++) begin
            m2_req = i[0];
            tick();
            chk("tie_nopre", m1_grant, 1);
            chk("tie_nopre2", m2_grant, 0);
        end
        m1_req = 0;
        tick();
        chk("rel_g1", m1_grant, 0);
        chk("rel_g2", m2_grant, 0);
        chk("rel_dmode", d_mode, 0);
        chk("rel_dwr", d_wr_bus, 0);
        tick();
        chk("idl_g2", m2_grant, 0);
        chk("idl_dmode", d_mode, 0);
        chk("idl_dmv", d_master_valid, 0);
        tick();
        chk("tie2_g2", m2_grant, 1);
        chk("tie2_dwr", d_wr_bus, 0);
        m2_wr_bus = 1; d_ack = 1;
        #1;
        chk("tie2_dwr1", d_wr_bus, 1);
        chk("tie2_ack2", m2_ack, 1);
        chk("tie2_ack1", m1_ack, 0);
        m2_req = 0; d_ack = 0;
        tick();
        tick();

        // Single request: m1 routing both ways, m2 side stays quiet
        m1_req = 1; d_rd_bus = 1; d_slave_valid = 1;
        tick();
        chk("one_g1", m1_grant, 1);
        chk("one_dwr", d_wr_bus, 1);
        chk("one_rd1", m1_rd_bus, 1);
        chk("one_sv1", m1_slave_valid, 1);
        chk("one_rd2", m2_rd_bus, 0);
        chk("one_sv2", m2_slave_valid, 0);
        m1_wr_bus = 0;
        #1;
        chk("one_dwr0", d_wr_bus, 0);
        m1_req = 0;
        tick();
        chk("one_relrd", m1_rd_bus, 0);
        tick();
        d_rd_bus = 0; d_slave_valid = 0; m1_wr_bus = 1;

        // Timeout: m2 holds 8 cycles, forced off, locked out until it drops
        m2_req = 1;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("to_hold", m2_grant, 1);
            chk("to_nopulse", timeout, 0);
            tick();
        end
        chk("to_g2off", m2_grant, 0);
        chk("to_pulse", timeout, 1);
        chk("to_id", timeout_id, 1);
        tick();
        chk("to_pulse_end", timeout, 0);
        chk("to_blk1", m2_grant, 0);
        tick();
        chk("to_blk2", m2_grant, 0);
        m1_req = 1;
        tick();
        chk("to_m1ok", m1_grant, 1);
        m1_req = 0;
        tick();
        tick();
        tick();
        chk("to_blk3", m2_grant, 0);
        m2_req = 0;
        tick();
        m2_req = 1;
        tick();
        chk("to_regrant", m2_grant, 1);
        m2_req = 0;
        tick();
        tick();

        // Drop in the last allowed cycle: normal release, no pulse, no lockout
        m1_req = 1;
        tick();
        repeat (7) tick();
        chk("exp_g1", m1_grant, 1);
        m1_req = 0;
        tick();
        chk("exp_off", m1_grant, 0);
        chk("exp_nopulse", timeout, 0);
        tick();
        m1_req = 1;
        tick();
        chk("exp_nolock", m1_grant, 1);
        m1_req = 0;
        tick();
        tick();

        // Async reset during GRANT2, then tie goes to m1
        m2_req = 1; m2_mode = 1; m2_wr_bus = 1; d_rd_bus = 1;
        tick();
        chk("ar_g2", m2_grant, 1);
        chk("ar_dmode", d_mode, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_g2off", m2_grant, 0);
        chk("ar_dmode0", d_mode, 0);
        chk("ar_dwr0", d_wr_bus, 0);
        chk("ar_rd2", m2_rd_bus, 0);
        #1;
        rstn = 1'b1;
        m1_req = 1;
        tick();
        chk("ar_nopulse", timeout, 0);
        chk("ar_tie_g1", m1_grant, 1);
        chk("ar_tie_g2", m2_grant, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
